// File: rtl/riscv_lsu_pkg.sv
// Shared LSU definitions: memory-op codes, access sizes, FSM state encodings.
package riscv_lsu_pkg;

   localparam int MemOpBus    = 3;
   localparam int LsuStateBus = 2;

   typedef enum logic [MemOpBus-1:0] {
      MEMOP_B  = 3'b000,
      MEMOP_H  = 3'b001,
      MEMOP_W  = 3'b010,
      MEMOP_BU = 3'b100,
      MEMOP_HU = 3'b101
   } memop_e;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } size_e;

   typedef enum logic [LsuStateBus-1:0] {
      LSU_IDLE = 2'd0,
      LSU_BUSY = 2'd1,
      LSU_RESP = 2'd2
   } lsu_state_e;

   // Unlisted op codes behave as word accesses.
   function automatic size_e memop_size(input logic [MemOpBus-1:0] op);
      case (op)
         MEMOP_B, MEMOP_BU: memop_size = SZ_B;
         MEMOP_H, MEMOP_HU: memop_size = SZ_H;
         default:           memop_size = SZ_W;
      endcase
   endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational LSU lane logic: byte enables, store replication, misalign detect
// on the request side; lane extract and sign/zero extension on the response side.
module riscv_lsu_align
   import riscv_lsu_pkg::*;
(
   input  logic [MemOpBus-1:0] req_memop,
   input  logic [1:0]          req_off,
   input  logic [31:0]         wdata,
   output logic [3:0]          be,
   output logic [31:0]         wdata_rep,
   output logic                misalign,
   input  logic [MemOpBus-1:0] rsp_memop,
   input  logic [1:0]          rsp_off,
   input  logic [31:0]         rdata,
   output logic [31:0]         rdata_ext
);

   logic [31:0] lane;

   always_comb begin
      be        = 4'hF;
      wdata_rep = wdata;
      misalign  = 1'b0;
      case (memop_size(req_memop))
         SZ_B: begin
            be        = 4'b0001 << req_off;
            wdata_rep = {4{wdata[7:0]}};
         end
         SZ_H: begin
            be        = 4'b0011 << req_off;
            wdata_rep = {2{wdata[15:0]}};
            misalign  = req_off[0];
         end
         default: begin
            be        = 4'hF;
            misalign  = |req_off;
         end
      endcase
   end

   // Shift the addressed lane down to bit 0 before extending.
   assign lane = rdata >> {rsp_off, 3'b000};

   always_comb begin
      rdata_ext = rdata;
      case (rsp_memop)
         MEMOP_B:  rdata_ext = {{24{lane[7]}}, lane[7:0]};
         MEMOP_BU: rdata_ext = {24'h0, lane[7:0]};
         MEMOP_H:  rdata_ext = {{16{lane[15]}}, lane[15:0]};
         MEMOP_HU: rdata_ext = {16'h0, lane[15:0]};
         default:  rdata_ext = rdata;
      endcase
   end

endmodule

// File: rtl/riscv_lsu.sv
// MEM-stage load/store unit: IDLE->BUSY->RESP, 3 cycles with a zero-wait bus, +1 per wait state.
// Stalls the pipeline from accept until ack; RISCV_LSU_TIMEOUT_EN aborts BUSY after TIMEOUT cycles.
module riscv_lsu
   import riscv_lsu_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid_i,
   input  logic                req_we_i,
   input  logic [MemOpBus-1:0] req_memop_i,
   input  logic [ADDR_W-1:0]   req_addr_i,
   input  logic [DATA_W-1:0]   req_wdata_i,
   output logic                stall_o,
   output logic [DATA_W-1:0]   rdata_o,
   output logic                rdata_valid_o,
   output logic                misalign_o,
   output logic                bus_err_o,
   output logic                bus_req_o,
   output logic                bus_we_o,
   output logic [3:0]          bus_be_o,
   output logic [ADDR_W-1:0]   bus_addr_o,
   output logic [DATA_W-1:0]   bus_wdata_o,
   input  logic                bus_ack_i,
   input  logic [DATA_W-1:0]   bus_rdata_i
);

   lsu_state_e          state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [3:0]          be_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [MemOpBus-1:0] memop_q;
   logic                we_q;

   logic                accept, done, timeout, tmo_hit;
   logic [3:0]          be_c;
   logic [DATA_W-1:0]   wdata_c, rdata_c;
   logic                misalign_c;

   riscv_lsu_align u_align (
      .req_memop (req_memop_i),
      .req_off   (req_addr_i[1:0]),
      .wdata     (req_wdata_i),
      .be        (be_c),
      .wdata_rep (wdata_c),
      .misalign  (misalign_c),
      .rsp_memop (memop_q),
      .rsp_off   (addr_q[1:0]),
      .rdata     (bus_rdata_i),
      .rdata_ext (rdata_c)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= LSU_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      stall_o = 1'b0;
      accept  = 1'b0;
      done    = 1'b0;
      timeout = 1'b0;
      case (state_q)
         LSU_IDLE: begin
            if (req_valid_i && !misalign_c) begin
               accept  = 1'b1;
               stall_o = 1'b1;
               state_d = LSU_BUSY;
            end
         end
         LSU_BUSY: begin
            stall_o = 1'b1;
            if (bus_ack_i) begin
               done    = 1'b1;
               state_d = LSU_RESP;
            end else if (tmo_hit) begin
               timeout = 1'b1;
               state_d = LSU_RESP;
            end
         end
         LSU_RESP: state_d = LSU_IDLE;
         default:  state_d = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q        <= '0;
         be_q          <= '0;
         wdata_q       <= '0;
         memop_q       <= '0;
         we_q          <= 1'b0;
         rdata_o       <= '0;
         rdata_valid_o <= 1'b0;
         misalign_o    <= 1'b0;
      end else begin
         misalign_o    <= (state_q == LSU_IDLE) && req_valid_i && misalign_c;
         rdata_valid_o <= done && !we_q;
         if (accept) begin
            addr_q  <= req_addr_i;
            be_q    <= be_c;
            wdata_q <= wdata_c;
            memop_q <= req_memop_i;
            we_q    <= req_we_i;
         end
         if (done && !we_q) rdata_o <= rdata_c;
         else if (timeout)  rdata_o <= '0;
      end
   end

`ifdef RISCV_LSU_TIMEOUT_EN
   localparam int CntW = $clog2(TIMEOUT + 1);
   logic [CntW-1:0] tmo_cnt_q;

   // An ack in the final counted cycle takes priority via the FSM ordering.
   assign tmo_hit = (tmo_cnt_q == CntW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_q <= '0;
         bus_err_o <= 1'b0;
      end else begin
         bus_err_o <= timeout;
         if (accept)
            tmo_cnt_q <= '0;
         else if (state_q == LSU_BUSY && !bus_ack_i)
            tmo_cnt_q <= tmo_cnt_q + CntW'(1);
      end
   end
`else
   assign tmo_hit   = 1'b0;
   assign bus_err_o = 1'b0;
`endif

   assign bus_req_o   = (state_q == LSU_BUSY);
   assign bus_we_o    = we_q;
   assign bus_be_o    = be_q;
   assign bus_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
   assign bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed self-checking bench for riscv_lsu (timeout case only with RISCV_LSU_TIMEOUT_EN).
module tb_riscv_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_i, req_we_i;
   logic [2:0]  req_memop_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic        stall_o, rdata_valid_o, misalign_o, bus_err_o;
   logic [31:0] rdata_o;
   logic        bus_req_o, bus_we_o;
   logic [3:0]  bus_be_o;
   logic [31:0] bus_addr_o, bus_wdata_o;
   logic        bus_ack_i;
   logic [31:0] bus_rdata_i;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   riscv_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid_i   (req_valid_i),
      .req_we_i      (req_we_i),
      .req_memop_i   (req_memop_i),
      .req_addr_i    (req_addr_i),
      .req_wdata_i   (req_wdata_i),
      .stall_o       (stall_o),
      .rdata_o       (rdata_o),
      .rdata_valid_o (rdata_valid_o),
      .misalign_o    (misalign_o),
      .bus_err_o     (bus_err_o),
      .bus_req_o     (bus_req_o),
      .bus_we_o      (bus_we_o),
      .bus_be_o      (bus_be_o),
      .bus_addr_o    (bus_addr_o),
      .bus_wdata_o   (bus_wdata_o),
      .bus_ack_i     (bus_ack_i),
      .bus_rdata_i   (bus_rdata_i)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Full access with a given number of bus wait states; called just after a clock edge.
   task automatic do_access(input string tag, input logic we, input logic [2:0] op,
                            input logic [31:0] addr, input logic [31:0] wd, input int waits,
                            input logic [31:0] rd, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd, input logic [31:0] exp_rd);
      int stalls = 0;
      req_valid_i = 1'b1; req_we_i = we; req_memop_i = op;
      req_addr_i = addr;  req_wdata_i = wd;
      #1;
      if (stall_o) stalls++;
      check({tag, "_acc_req"}, {31'h0, bus_req_o}, 32'h0);
      for (int i = 0; i <= waits; i++) begin
         tick();
         bus_ack_i   = (i == waits);
         bus_rdata_i = (i == waits) ? rd : 32'h0;
         #1;
         if (stall_o) stalls++;
         check({tag, "_req"},  {31'h0, bus_req_o}, 32'h1);
         check({tag, "_addr"}, bus_addr_o, {addr[31:2], 2'b00});
         check({tag, "_be"},   {28'h0, bus_be_o}, {28'h0, exp_be});
         check({tag, "_we"},   {31'h0, bus_we_o}, {31'h0, we});
         if (we) check({tag, "_wdata"}, bus_wdata_o, exp_wd);
      end
      tick();
      bus_ack_i = 1'b0; req_valid_i = 1'b0;
      #1;
      if (stall_o) stalls++;
      check({tag, "_resp_req"}, {31'h0, bus_req_o}, 32'h0);
      check({tag, "_rvalid"},   {31'h0, rdata_valid_o}, {31'h0, !we});
      check({tag, "_err"},      {31'h0, bus_err_o}, 32'h0);
      if (!we) check({tag, "_rdata"}, rdata_o, exp_rd);
      check({tag, "_stalls"}, stalls, waits + 2);
      tick();
      check({tag, "_rvalid_off"}, {31'h0, rdata_valid_o}, 32'h0);
   endtask

   initial begin
      rst = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_memop_i = 3'b000;
      req_addr_i = 32'h0; req_wdata_i = 32'h0; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
      tick(); tick();
      check("rst_req",    {31'h0, bus_req_o}, 32'h0);
      check("rst_stall",  {31'h0, stall_o}, 32'h0);
      check("rst_rdata",  rdata_o, 32'h0);
      check("rst_rvalid", {31'h0, rdata_valid_o}, 32'h0);
      check("rst_mis",    {31'h0, misalign_o}, 32'h0);
      check("rst_err",    {31'h0, bus_err_o}, 32'h0);
      rst = 1'b0;
      tick();

      //         tag    we    op      addr          wdata         w  bus_rdata     be       exp_wdata     exp_rdata
      do_access("lw",   1'b0, 3'b010, 32'h0000_0100, 32'h0,        0, 32'hDEADBEEF, 4'hF,    32'h0,        32'hDEADBEEF);
      do_access("lb",   1'b0, 3'b000, 32'h0000_0103, 32'h0,        0, 32'h80FF1234, 4'b1000, 32'h0,        32'hFFFFFF80);
      do_access("lbu",  1'b0, 3'b100, 32'h0000_0103, 32'h0,        0, 32'h80FF1234, 4'b1000, 32'h0,        32'h00000080);
      do_access("lb1",  1'b0, 3'b000, 32'h0000_0101, 32'h0,        1, 32'h80FF1234, 4'b0010, 32'h0,        32'h00000012);
      do_access("lh",   1'b0, 3'b001, 32'h0000_0102, 32'h0,        0, 32'h80FF1234, 4'b1100, 32'h0,        32'hFFFF80FF);
      do_access("lhu",  1'b0, 3'b101, 32'h0000_0102, 32'h0,        0, 32'h80FF1234, 4'b1100, 32'h0,        32'h000080FF);
      do_access("sh",   1'b1, 3'b001, 32'h0000_0102, 32'h0000ABCD, 0, 32'h0,        4'b1100, 32'hABCDABCD, 32'h0);
      do_access("sb",   1'b1, 3'b000, 32'h0000_0101, 32'h1234565A, 0, 32'h0,        4'b0010, 32'h5A5A5A5A, 32'h0);
      do_access("sw3",  1'b1, 3'b010, 32'h0000_0200, 32'h12345678, 3, 32'h0,        4'hF,    32'h12345678, 32'h0);

      // Misaligned word: no bus access, one-cycle misalign pulse, no stall.
      req_valid_i = 1'b1; req_we_i = 1'b0; req_memop_i = 3'b010; req_addr_i = 32'h101;
      #1;
      check("mis_stall0", {31'h0, stall_o}, 32'h0);
      tick();
      req_valid_i = 1'b0;
      #1;
      check("mis_pulse",  {31'h0, misalign_o}, 32'h1);
      check("mis_req",    {31'h0, bus_req_o}, 32'h0);
      check("mis_stall1", {31'h0, stall_o}, 32'h0);
      tick();
      check("mis_off",    {31'h0, misalign_o}, 32'h0);
      check("mis_req2",   {31'h0, bus_req_o}, 32'h0);

      // Reset in the second BUSY cycle, then a stray ack must be ignored.
      req_valid_i = 1'b1; req_we_i = 1'b1; req_memop_i = 3'b010;
      req_addr_i = 32'h300; req_wdata_i = 32'hCAFEF00D;
      tick();
      check("rb_busy1", {31'h0, bus_req_o}, 32'h1);
      tick();
      check("rb_busy2", {31'h0, bus_req_o}, 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0; req_valid_i = 1'b0;
      #1;
      check("rb_req",   {31'h0, bus_req_o}, 32'h0);
      check("rb_stall", {31'h0, stall_o}, 32'h0);
      bus_ack_i = 1'b1; bus_rdata_i = 32'h11111111;
      tick();
      bus_ack_i = 1'b0;
      #1;
      check("rb_late_req",    {31'h0, bus_req_o}, 32'h0);
      check("rb_late_rvalid", {31'h0, rdata_valid_o}, 32'h0);
      check("rb_late_stall",  {31'h0, stall_o}, 32'h0);
      tick();
      do_access("post_rst", 1'b0, 3'b100, 32'h0000_0102, 32'h0, 0, 32'h00AB0000, 4'b0100, 32'h0, 32'h000000AB);

`ifdef RISCV_LSU_TIMEOUT_EN
      begin
         int req_cycles = 0;
         req_valid_i = 1'b1; req_we_i = 1'b0; req_memop_i = 3'b010; req_addr_i = 32'h400;
         for (int i = 0; i < 10; i++) begin
            tick();
            req_valid_i = 1'b0;
            if (bus_req_o) req_cycles++;
            else break;
         end
         check("tmo_cycles", req_cycles, 4);
         check("tmo_err",    {31'h0, bus_err_o}, 32'h1);
         check("tmo_rdata",  rdata_o, 32'h0);
         check("tmo_rvalid", {31'h0, rdata_valid_o}, 32'h0);
         check("tmo_stall",  {31'h0, stall_o}, 32'h0);
         tick();
         check("tmo_err_off", {31'h0, bus_err_o}, 32'h0);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
